instr_fetch: RTL and testbench
==============================

# instr_fetch

Program loader and fetch sequencer that sits upstream of `controlunit` in the single-cycle processor. A loader streams instruction words into an internal instruction memory over a valid/ready port. On `start`, the block sequences through the stored program and presents one instruction per cycle, with its `insmsb` and `func` fields split out to drive `controlunit` directly. It stops on a halt instruction or at the end of the loaded program.

## Interface
- `DEPTH`, 64: instruction memory words; must be a power of two.
- `AW`, 6: address width, log2(`DEPTH`).
- `HALT_FUNC`, 6'b111111: `func` value that marks a halt instruction when `insmsb`=0.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `clear` in 1: discards the loaded program and returns to IDLE.
- `ld_valid` in 1: load beat valid.
- `ld_data` in 32: instruction word to store.
- `ld_last` in 1: marks the final word of the program.
- `ld_ready` out 1: block accepts a load beat.
- `start` in 1: begin executing from address 0.
- `stall` in 1: hold the presented instruction.
- `instr` out 32: presented instruction word.
- `insmsb` out 1: `instr[31]`, to `controlunit.insmsb`.
- `func` out 6: `instr[5:0]`, to `controlunit.func`.
- `pc` out `AW`: address of the presented `instr`.
- `instr_valid` out 1: `instr` is a live instruction.
- `halted` out 1: program finished.
- `prog_len` out `AW`+1: number of loaded words.

## Operation
- States:
  - IDLE: loading is allowed.
  - RUN: instructions are being presented.
  - HALT: the program has finished.
- Priority within a cycle: `rst_n` low, then `clear`, then state logic.
- `clear`, from any state:
  - Next state is IDLE.
  - `prog_len`=0, write pointer=0, loaded flag=0.
  - `instr_valid`=0, `halted`=0.
  - Memory contents are not erased.
- `ld_ready` = (state==IDLE) & !loaded & (`prog_len`<`DEPTH`).
- Load beat: when `ld_valid` & `ld_ready`:
  - Write mem[`prog_len`]=`ld_data`, then `prog_len`+=1.
  - If `ld_last` is also high, set loaded.
  - When `prog_len` reaches `DEPTH`, `ld_ready` drops; no wrap, and the write pointer never overflows.
- Start from IDLE:
  - `start` with `prog_len`=0 is ignored.
  - `start` in a cycle where a load beat is accepted is ignored.
  - Otherwise: `instr`<=mem[0], `pc`<=0, `instr_valid`<=1, state<=RUN.
- Start from HALT: `start` re-runs the program from address 0, as above; `halted`<=0.
- RUN with `stall`=1: `instr`, `pc` and `instr_valid` all hold.
- RUN with `stall`=0, finish case:
  - Condition: the presented instruction is a halt (`insmsb`=0 and `func`==`HALT_FUNC`), or `pc`==`prog_len`-1.
  - Then `instr_valid`<=0, `halted`<=1, state<=HALT.
  - `instr` and `pc` hold their last values.
- RUN with `stall`=0, otherwise: `pc`<=`pc`+1 and `instr`<=mem[`pc`+1].
- `start` and `ld_valid` are ignored during RUN.
- `insmsb` and `func` are combinational slices of `instr`.

## Timing
- Reset values:
  - State IDLE.
  - `instr`=0, `pc`=0, `instr_valid`=0, `halted`=0, `prog_len`=0, loaded=0.
  - `ld_ready`=1 in the first cycle after reset.
- Load throughput: one beat per cycle.
- Load-to-use: a word written at edge N is readable by a `start` sampled at edge N+1 or later.
- Start latency: `start` sampled at edge N gives `instr_valid`=1 with `pc`=0 after edge N.
- Steady state: one instruction per unstalled cycle.
- Halt instructions: a halt is presented for at least one cycle with `instr_valid`=1. `halted` rises one edge after the halt instruction's last unstalled cycle.
- Stall: `stall` sampled high at an edge freezes the presented instruction through that edge; no bubble is inserted on release.
- Reset mid-operation: `rst_n` low at any edge forces the reset values at that edge, including `prog_len`=0.
- Memory: synchronous write, registered read into `instr`. Memory contents are not reset.

## Test plan
- Basic run:
  - Stimulus: reset, load 0x00000001, 0x00000002, 0x00000003 with `ld_last` on the 3rd word, then `start`.
  - Response: `pc`=0, 1, 2 on consecutive cycles with `instr_valid`=1.
  - Response: the next cycle gives `instr_valid`=0, `halted`=1, `ld_ready`=0.
- Halt decode:
  - Stimulus: load 0x00000030, 0x80000000, 0x0000003F, 0x00000005, then `start`.
  - Response: `insmsb`/`func` = 0/110000, then 1/000000, then 0/111111 at `pc`=2.
  - Response: then `halted`=1; `pc`=3 is never presented.
- Stall:
  - Stimulus: assert `stall` for 2 cycles while `pc`=1.
  - Response: `pc`=1, `instr`=mem[1] and `instr_valid`=1 for 3 cycles, then `pc`=2 on the next cycle.
- Full memory:
  - Stimulus: stream 65 beats without `ld_last`.
  - Response: 64 beats accepted, `ld_ready`=0 after the 64th, `prog_len`=64.
  - Response: a run ends with `halted`=1 after `pc`=63.
- Rerun, clear and empty start:
  - Stimulus: `start` in HALT.
  - Response: `pc`=0 is presented again.
  - Stimulus: `clear`, then `start`.
  - Response: `clear` gives IDLE, `prog_len`=0, `ld_ready`=1, and `instr_valid` stays 0 after the following `start`.
- Reset mid-run:
  - Stimulus: `rst_n`=0 for one edge while `pc`=2.
  - Response: `instr_valid`=0, `pc`=0, `instr`=0, `prog_len`=0, `halted`=0.
  - Response: a subsequent `start` is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Load port and fetch-presentation bundle for instr_fetch.
// The loader/consumer side uses the master modport; instr_fetch uses slave.
interface instr_fetch_if #(
  parameter int AW = 6
) ();
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [31:0]   instr;
  logic          insmsb;
  logic [5:0]    func;
  logic [AW-1:0] pc;
  logic          instr_valid;
  logic          halted;
  logic [AW:0]   prog_len;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, instr, insmsb, func, pc, instr_valid, halted, prog_len
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, instr, insmsb, func, pc, instr_valid, halted, prog_len
  );
endinterface

// File: rtl/instr_fetch.sv
// Program loader and fetch sequencer feeding controlunit.
// Words are streamed into a local instruction memory while IDLE; start
// presents them one per unstalled cycle until a halt word or the last word.
module instr_fetch #(
  parameter int         DEPTH     = 64,
  parameter int         AW        = 6,
  parameter logic [5:0] HALT_FUNC = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic        stall,
  instr_fetch_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_instr;
  logic [AW-1:0] r_pc;
  logic          r_valid;
  logic          r_halted;
  logic          r_loaded;
  logic [AW:0]   r_len;

  logic          w_ready;
  logic          w_beat;
  logic          w_is_halt;
  logic          w_last;
  logic          w_start_ok;
  logic [AW-1:0] w_pc_nxt;

  // prog_len doubles as the write pointer; it saturates at DEPTH because
  // ld_ready drops there, so the memory index never wraps.
  assign w_ready    = (r_state == S_IDLE) && !r_loaded && (r_len < LP_DEPTH);
  assign w_beat     = bus.ld_valid && w_ready;
  assign w_is_halt  = !r_instr[31] && (r_instr[5:0] == HALT_FUNC);
  assign w_last     = ({1'b0, r_pc} == (r_len - 1'b1));
  // A start that collides with an accepted load beat is dropped so the
  // program cannot begin while it is still being written.
  assign w_start_ok = start && (r_len != '0) && !w_beat;
  assign w_pc_nxt   = r_pc + 1'b1;

  // Instruction memory write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_beat) begin
      r_mem[r_len[AW-1:0]] <= bus.ld_data;
    end
  end

  // Load/run/halt sequencer with registered instruction read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_loaded <= 1'b0;
      r_len    <= '0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_loaded <= 1'b0;
      r_len    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_len <= r_len + 1'b1;
            if (bus.ld_last) begin
              r_loaded <= 1'b1;
            end
          end else if (w_start_ok) begin
            r_instr <= r_mem[0];
            r_pc    <= '0;
            r_valid <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (w_is_halt || w_last) begin
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_pc    <= w_pc_nxt;
              r_instr <= r_mem[w_pc_nxt];
            end
          end
        end
        S_HALT: begin
          if (w_start_ok) begin
            r_instr  <= r_mem[0];
            r_pc     <= '0;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ld_ready    = w_ready;
  assign bus.instr       = r_instr;
  assign bus.insmsb      = r_instr[31];
  assign bus.func        = r_instr[5:0];
  assign bus.pc          = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;
  assign bus.prog_len    = r_len;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// programs and stalls, compared against a program-level reference model.
module tb_instr_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_if #(.AW(6)) bus ();

  instr_fetch #(.DEPTH(64), .AW(6), .HALT_FUNC(6'h3F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .start (start),
    .stall (stall),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what has been loaded, and whether the program is closed.
  logic [31:0] m_mem [64];
  int          m_len    = 0;
  bit          m_loaded = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit is_halt(input logic [31:0] w);
    return (w[31] == 1'b0) && (w[5:0] == 6'h3F);
  endfunction

  task automatic check_reset_vals();
    check("rst_instr",    bus.instr,       0);
    check("rst_pc",       bus.pc,          0);
    check("rst_valid",    bus.instr_valid, 0);
    check("rst_halted",   bus.halted,      0);
    check("rst_prog_len", bus.prog_len,    0);
    check("rst_ld_ready", bus.ld_ready,    1);
  endtask

  task automatic load_word(input logic [31:0] d, input bit last, input bit with_start);
    bit exp_rdy;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    start        = with_start;
    exp_rdy      = (m_len < 64) && !m_loaded;
    check("ld_ready", bus.ld_ready, exp_rdy);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    start        = 1'b0;
    if (exp_rdy) begin
      m_mem[m_len] = d;
      m_len++;
      if (last) m_loaded = 1'b1;
    end
    check("prog_len", bus.prog_len, m_len);
    if (with_start) check("start_during_load", bus.instr_valid, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear    = 1'b0;
    m_len    = 0;
    m_loaded = 1'b0;
    check("clr_prog_len", bus.prog_len,    0);
    check("clr_ld_ready", bus.ld_ready,    1);
    check("clr_valid",    bus.instr_valid, 0);
    check("clr_halted",   bus.halted,      0);
  endtask

  // mode 0: no stalls, 1: random stalls, 2: two stall cycles while pc=1
  task automatic start_and_run(input int mode);
    int seq[$];
    int idx;
    int stalls_at1;
    bit st;
    logic [31:0] w;
    for (int a = 0; a < m_len; a++) begin
      seq.push_back(a);
      if (is_halt(m_mem[a])) break;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    stalls_at1 = 0;
    while (idx < seq.size()) begin
      w = m_mem[seq[idx]];
      check("run_valid",  bus.instr_valid, 1);
      check("run_pc",     bus.pc,          seq[idx]);
      check("run_instr",  bus.instr,       w);
      check("run_insmsb", bus.insmsb,      w[31]);
      check("run_func",   bus.func,        w[5:0]);
      check("run_halted", bus.halted,      0);
      case (mode)
        1:       st = ($urandom_range(0, 3) == 0);
        2:       st = (seq[idx] == 1) && (stalls_at1 < 2);
        default: st = 1'b0;
      endcase
      stall = st;
      tick();
      stall = 1'b0;
      if (st) begin
        if (seq[idx] == 1) stalls_at1++;
      end else begin
        idx++;
      end
    end
    check("end_valid",    bus.instr_valid, 0);
    check("end_halted",   bus.halted,      1);
    check("end_pc",       bus.pc,          seq[seq.size()-1]);
    check("end_instr",    bus.instr,       m_mem[seq[seq.size()-1]]);
    check("end_ld_ready", bus.ld_ready,    0);
    if (mode == 2) check("stall_count", stalls_at1, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int n;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_vals();

    // Basic run
    load_word(32'h0000_0001, 1'b0, 1'b0);
    load_word(32'h0000_0002, 1'b0, 1'b0);
    load_word(32'h0000_0003, 1'b1, 1'b0);
    check("basic_closed_ready", bus.ld_ready, 0);
    start_and_run(0);

    // Halt decode
    do_clear();
    load_word(32'h0000_0030, 1'b0, 1'b0);
    load_word(32'h8000_0000, 1'b0, 1'b0);
    load_word(32'h0000_003F, 1'b0, 1'b0);
    load_word(32'h0000_0005, 1'b1, 1'b0);
    start_and_run(0);

    // Rerun from HALT with a two-cycle stall at pc=1
    start_and_run(2);

    // Empty start after clear
    do_clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_valid", bus.instr_valid, 0);
    tick();
    check("empty_start_valid2", bus.instr_valid, 0);
    check("empty_start_ready",  bus.ld_ready,    1);

    // Full memory: 65 beats, no ld_last, no halt words
    for (int i = 0; i < 65; i++) load_word($urandom & 32'hFFFF_FFFE, 1'b0, 1'b0);
    check("full_prog_len", bus.prog_len, 64);
    check("full_ld_ready", bus.ld_ready, 0);
    start_and_run(1);

    // Randomized programs with occasional halt words
    for (int it = 0; it < 4; it++) begin
      do_clear();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if ($urandom_range(0, 5) == 0) w = {1'b0, w[30:6], 6'h3F};
        load_word(w, i == n - 1, i == 0);
      end
      start_and_run(1);
      start_and_run(1);
    end

    // Reset while pc=2
    do_clear();
    for (int i = 0; i < 5; i++) load_word(32'h8000_0000 | i, i == 4, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_pc", bus.pc, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_len    = 0;
    m_loaded = 1'b0;
    check_reset_vals();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_reset_start_valid", bus.instr_valid, 0);
    check("post_reset_start_pc",    bus.pc,          0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
